flash_read_cache: RTL and testbench
===================================

Name: flash_read_cache

Overview:
- Read-side front end for the on-chip Intel UFM flash data port.
- Accepts single 32-bit word read requests from the internal memory bus.
- Issues Avalon-MM burst reads to the flash IP and keeps the most recently fetched burst in a one-line buffer, so sequential accesses hit without a flash access.
- Sits directly upstream of the flash IP; its Avalon master ports connect one-to-one to the IP's avmm_data_* slave ports.

Parameters:
- BURST_LENGTH, 2, words per flash burst and per line; legal values 1 or 2; drives avmm_data_burstcount.
- CACHE_ENABLE, 1, when 0 every request misses and the line is never marked valid.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- invalidate  in  1  one-cycle pulse; drops the buffered line (flash was erased or programmed elsewhere).
- req_valid  in  1  read request.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_address  in  16  32-bit word address.
- rsp_valid  out  1  one-cycle pulse; rsp_data is valid in that cycle; no backpressure.
- rsp_data  out  32  read data.
- avmm_data_addr  out  16  flash word address, aligned to BURST_LENGTH.
- avmm_data_read  out  1  Avalon read command.
- avmm_data_burstcount  out  2  constant BURST_LENGTH.
- avmm_data_waitrequest  in  1  command stall from the flash IP.
- avmm_data_readdata  in  32  returned beat.
- avmm_data_readdatavalid  in  1  beat valid.

Behaviour:
- Reset values:
  - FSM = IDLE; req_ready = 1 (combinational in IDLE).
  - rsp_valid = 0; rsp_data = 0.
  - avmm_data_read = 0; avmm_data_addr = 0.
  - Line valid = 0; beat counter = 0; invalidate-pending = 0.
- Line tag = req_address[15:log2(BURST_LENGTH)]. Line base = req_address with the low log2(BURST_LENGTH) bits cleared. Word offset = low bits.
- Only one request is outstanding at a time. req_ready = 1 only in IDLE.
- IDLE:
  - On accept with hit (line valid && tag match && CACHE_ENABLE && !invalidate): rsp_valid = 1 the next cycle, rsp_data = the buffered word. Stay in IDLE.
  - On accept with miss: latch the address and go to ISSUE.
- ISSUE:
  - avmm_data_read = 1, avmm_data_addr = line base, held stable while avmm_data_waitrequest = 1.
  - The command is accepted in the first cycle with avmm_data_read && !avmm_data_waitrequest. On the next cycle avmm_data_read = 0; go to RECEIVE.
  - Line valid is cleared on entering ISSUE.
- RECEIVE:
  - Each avmm_data_readdatavalid writes avmm_data_readdata to buffer[beat counter], then the counter increments.
  - On the final beat (counter == BURST_LENGTH-1):
    - The next cycle gives rsp_valid = 1, rsp_data = buffer[latched offset].
    - FSM returns to IDLE.
    - The line is marked valid with the latched tag unless invalidate-pending or !CACHE_ENABLE.
    - The counter and invalidate-pending are cleared.
- Miss latency: avmm_data_read rises 1 cycle after accept. rsp_valid follows 1 cycle after the last readdatavalid. A new request may be accepted in that same rsp_valid cycle.
- Invalidate:
  - In IDLE: clears valid immediately. If a request is accepted in the same cycle, it is treated as a miss.
  - During ISSUE/RECEIVE: sets invalidate-pending. The burst completes and data is still returned, but the line stays invalid.
- readdatavalid arriving in IDLE or ISSUE is ignored (protocol violation; assertion in the bench).
- Address wrap: 0xFFFF with BURST_LENGTH=2 gives line base 0xFFFE. No crossing beyond 0xFFFF is possible.
- Reset mid-burst: FSM goes to IDLE, avmm_data_read drops the same cycle, and the in-flight response is discarded. The flash IP shares the reset, so no late beats are expected.
- req_address changes while not accepted are don't-care.

Decomposition:
- Package flash_pkg holds:
  - the state enum (IDLE, ISSUE, RECEIVE);
  - FLASH_ADDR_WIDTH = 16, FLASH_DATA_WIDTH = 32, MAX_BURST = 2.
- One sub-module, flash_line_buffer: BURST_LENGTH x 32 storage, tag/valid registers, hit compare, and write-by-beat-index. The FSM and Avalon sequencing stay in flash_read_cache.

Test Plan:
- Cold miss, then a sequential hit.
  - Stimulus: req 0x0010 then 0x0011; flash model returns 0xAAAA0000 and 0xBBBB0001 with waitrequest = 0 and a 3-cycle read latency.
  - Required: one burst at addr 0x0010 with burstcount 2. rsp 0xAAAA0000 one cycle after the last beat. The second request gives rsp 0xBBBB0001 exactly one cycle after accept, with no avmm_data_read.
- Waitrequest stall.
  - Stimulus: waitrequest held high for 5 cycles on a miss to 0x0021.
  - Required: avmm_data_read and addr 0x0020 stay stable all 5 cycles; exactly one command is accepted; rsp is the second beat.
- Invalidate during RECEIVE.
  - Stimulus: miss to 0x0100, invalidate pulse between beats, then req 0x0101.
  - Required: the first rsp is correct; the second request misses and issues a new burst at 0x0100.
- Invalidate coincident with a hit request in IDLE.
  - Required: treated as a miss; burst issued.
- Boundary: req 0xFFFF.
  - Required: burst at 0xFFFE; rsp is the second beat. A following req 0xFFFE hits.
- Reset mid-burst.
  - Stimulus: assert reset after the first beat.
  - Required: avmm_data_read = 0, rsp_valid never pulses, req_ready = 1 the next cycle. The next req to the same line misses.

Source files
------------

// File: rtl/flash_pkg.sv
// Shared widths, FSM state type and line-address helper for the flash read cache.
package flash_pkg;

  localparam int unsigned FLASH_ADDR_WIDTH = 16;
  localparam int unsigned FLASH_DATA_WIDTH = 32;
  localparam int unsigned MAX_BURST        = 2;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StReceive
  } flash_state_e;

  // Clears the word-offset bits so the address points at the first word of its line.
  function automatic logic [FLASH_ADDR_WIDTH-1:0] line_base(
    input logic [FLASH_ADDR_WIDTH-1:0] addr,
    input int unsigned                 burst
  );
    logic [FLASH_ADDR_WIDTH-1:0] mask;
    mask = FLASH_ADDR_WIDTH'(burst - 1);
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/flash_line_buffer.sv
// One-line read buffer: per-beat word storage plus tag/valid and the hit compare.
module flash_line_buffer
  import flash_pkg::*;
#(
  parameter int unsigned BURST_LENGTH = 2,
  parameter bit          CACHE_ENABLE = 1'b1,
  localparam int unsigned IdxW        = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        clear_i,
  input  logic                        fill_set_i,
  input  logic [FLASH_ADDR_WIDTH-1:0] fill_base_i,
  input  logic [FLASH_ADDR_WIDTH-1:0] lookup_base_i,
  output logic                        hit_o,
  input  logic                        wr_en_i,
  input  logic [IdxW-1:0]             wr_idx_i,
  input  logic [FLASH_DATA_WIDTH-1:0] wr_data_i,
  input  logic [IdxW-1:0]             rd_idx_i,
  output logic [FLASH_DATA_WIDTH-1:0] rd_data_o
);

  logic [FLASH_DATA_WIDTH-1:0] data_q [BURST_LENGTH];
  logic [FLASH_DATA_WIDTH-1:0] data_d [BURST_LENGTH];
  logic [FLASH_ADDR_WIDTH-1:0] tag_q, tag_d;
  logic                        valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    if (wr_en_i && (int'(wr_idx_i) < BURST_LENGTH)) begin
      data_d[wr_idx_i] = wr_data_i;
    end
    if (fill_set_i && CACHE_ENABLE) begin
      valid_d = 1'b1;
      tag_d   = fill_base_i;
    end
    // A clear always wins over a fill landing in the same cycle.
    if (clear_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_q  <= '{default: '0};
      tag_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      tag_q   <= tag_d;
      valid_q <= valid_d;
    end
  end

  assign hit_o     = CACHE_ENABLE && valid_q && (tag_q == lookup_base_i);
  assign rd_data_o = data_q[rd_idx_i];

endmodule

// File: rtl/flash_read_cache.sv
// Single-word read front end for the UFM data port; one outstanding burst, one buffered line.
module flash_read_cache
  import flash_pkg::*;
#(
  parameter int unsigned BURST_LENGTH = 2,
  parameter bit          CACHE_ENABLE = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        invalidate,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [FLASH_ADDR_WIDTH-1:0] req_address,
  output logic                        rsp_valid,
  output logic [FLASH_DATA_WIDTH-1:0] rsp_data,
  output logic [FLASH_ADDR_WIDTH-1:0] avmm_data_addr,
  output logic                        avmm_data_read,
  output logic [1:0]                  avmm_data_burstcount,
  input  logic                        avmm_data_waitrequest,
  input  logic [FLASH_DATA_WIDTH-1:0] avmm_data_readdata,
  input  logic                        avmm_data_readdatavalid
);

  localparam int unsigned IdxW = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;
  localparam logic [FLASH_ADDR_WIDTH-1:0] OffMask  = FLASH_ADDR_WIDTH'(BURST_LENGTH - 1);
  localparam logic [IdxW-1:0]             LastBeat = IdxW'(BURST_LENGTH - 1);

  flash_state_e                state_q, state_d;
  logic [FLASH_ADDR_WIDTH-1:0] line_base_q, line_base_d;
  logic [IdxW-1:0]             off_q, off_d;
  logic [IdxW-1:0]             beat_q, beat_d;
  logic                        inv_pend_q, inv_pend_d;
  logic                        rsp_valid_q, rsp_valid_d;
  logic [FLASH_DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic [FLASH_ADDR_WIDTH-1:0] req_base;
  logic [IdxW-1:0]             req_off;
  logic                        buf_hit, buf_clear, buf_fill, buf_wr_en;
  logic [IdxW-1:0]             buf_rd_idx;
  logic [FLASH_DATA_WIDTH-1:0] buf_rd_data;

  assign req_base = line_base(req_address, BURST_LENGTH);
  assign req_off  = IdxW'(req_address & OffMask);

  always_comb begin
    state_d        = state_q;
    line_base_d    = line_base_q;
    off_d          = off_q;
    beat_d         = beat_q;
    inv_pend_d     = inv_pend_q;
    rsp_valid_d    = 1'b0;
    rsp_data_d     = rsp_data_q;
    buf_clear      = invalidate;
    buf_fill       = 1'b0;
    buf_wr_en      = 1'b0;
    buf_rd_idx     = off_q;
    req_ready      = 1'b0;
    avmm_data_read = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready  = 1'b1;
        buf_rd_idx = req_off;
        if (req_valid) begin
          if (buf_hit && !invalidate) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = buf_rd_data;
          end else begin
            line_base_d = req_base;
            off_d       = req_off;
            buf_clear   = 1'b1;
            state_d     = StIssue;
          end
        end
      end
      StIssue: begin
        // Gated by reset so the command drops in the reset cycle itself.
        avmm_data_read = !reset;
        inv_pend_d     = inv_pend_q | invalidate;
        if (!avmm_data_waitrequest) begin
          state_d = StReceive;
        end
      end
      StReceive: begin
        inv_pend_d = inv_pend_q | invalidate;
        if (avmm_data_readdatavalid) begin
          buf_wr_en = 1'b1;
          beat_d    = beat_q + 1'b1;
          if (beat_q == LastBeat) begin
            rsp_valid_d = 1'b1;
            // The final beat is still being written, so bypass it straight to the response.
            rsp_data_d  = (off_q == beat_q) ? avmm_data_readdata : buf_rd_data;
            buf_fill    = !inv_pend_q && !invalidate;
            beat_d      = '0;
            inv_pend_d  = 1'b0;
            state_d     = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      line_base_q <= '0;
      off_q       <= '0;
      beat_q      <= '0;
      inv_pend_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      line_base_q <= line_base_d;
      off_q       <= off_d;
      beat_q      <= beat_d;
      inv_pend_q  <= inv_pend_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  flash_line_buffer #(
    .BURST_LENGTH (BURST_LENGTH),
    .CACHE_ENABLE (CACHE_ENABLE)
  ) u_line_buffer (
    .clk_i         (clk),
    .reset_i       (reset),
    .clear_i       (buf_clear),
    .fill_set_i    (buf_fill),
    .fill_base_i   (line_base_q),
    .lookup_base_i (req_base),
    .hit_o         (buf_hit),
    .wr_en_i       (buf_wr_en),
    .wr_idx_i      (beat_q),
    .wr_data_i     (avmm_data_readdata),
    .rd_idx_i      (buf_rd_idx),
    .rd_data_o     (buf_rd_data)
  );

  assign avmm_data_addr       = line_base_q;
  assign avmm_data_burstcount = 2'(BURST_LENGTH);
  assign rsp_valid            = rsp_valid_q;
  assign rsp_data             = rsp_data_q;

endmodule

// File: tb/tb_flash_read_cache.sv
// Directed bench for flash_read_cache with a hand-driven Avalon flash responder.
module tb_flash_read_cache;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        invalidate = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_address = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [15:0] avmm_data_addr;
  logic        avmm_data_read;
  logic [1:0]  avmm_data_burstcount;
  logic        avmm_data_waitrequest = 1'b0;
  logic [31:0] avmm_data_readdata = '0;
  logic        avmm_data_readdatavalid = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int cmd_count = 0;

  flash_read_cache #(
    .BURST_LENGTH (2),
    .CACHE_ENABLE (1'b1)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .invalidate              (invalidate),
    .req_valid               (req_valid),
    .req_ready               (req_ready),
    .req_address             (req_address),
    .rsp_valid               (rsp_valid),
    .rsp_data                (rsp_data),
    .avmm_data_addr          (avmm_data_addr),
    .avmm_data_read          (avmm_data_read),
    .avmm_data_burstcount    (avmm_data_burstcount),
    .avmm_data_waitrequest   (avmm_data_waitrequest),
    .avmm_data_readdata      (avmm_data_readdata),
    .avmm_data_readdatavalid (avmm_data_readdatavalid)
  );

  always #5 clk = ~clk;

  // Commands accepted by the flash IP.
  always @(posedge clk) begin
    if (avmm_data_read && !avmm_data_waitrequest) cmd_count <= cmd_count + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Miss: expects a burst at base, returns d0/d1 after a 3-cycle latency.
  task automatic miss(input string tag, input logic [15:0] a, input logic [15:0] base,
                      input logic [31:0] d0, input logic [31:0] d1, input int stall,
                      input bit inv_mid, input bit inv_at_req, input logic [31:0] exp_rsp);
    int c0;
    c0 = cmd_count;
    req_valid = 1'b1;
    req_address = a;
    invalidate = inv_at_req;
    avmm_data_waitrequest = (stall > 0);
    chk({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    invalidate = 1'b0;
    chk({tag, ".read"}, {31'd0, avmm_data_read}, 32'd1);
    chk({tag, ".addr"}, {16'd0, avmm_data_addr}, {16'd0, base});
    chk({tag, ".bcnt"}, {30'd0, avmm_data_burstcount}, 32'd2);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk({tag, ".stall_read"}, {31'd0, avmm_data_read}, 32'd1);
      chk({tag, ".stall_addr"}, {16'd0, avmm_data_addr}, {16'd0, base});
    end
    avmm_data_waitrequest = 1'b0;
    tick();
    chk({tag, ".read_drop"}, {31'd0, avmm_data_read}, 32'd0);
    chk({tag, ".one_cmd"}, 32'(cmd_count), 32'(c0 + 1));
    tick();
    tick();
    avmm_data_readdatavalid = 1'b1;
    avmm_data_readdata = d0;
    tick();
    if (inv_mid) begin
      avmm_data_readdatavalid = 1'b0;
      invalidate = 1'b1;
      tick();
      invalidate = 1'b0;
    end
    avmm_data_readdatavalid = 1'b1;
    avmm_data_readdata = d1;
    tick();
    avmm_data_readdatavalid = 1'b0;
    avmm_data_readdata = '0;
    chk({tag, ".rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, ".rsp_data"}, rsp_data, exp_rsp);
    chk({tag, ".ready_back"}, {31'd0, req_ready}, 32'd1);
    tick();
    chk({tag, ".rsp_pulse"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  task automatic hit(input string tag, input logic [15:0] a, input logic [31:0] exp_rsp);
    int c0;
    c0 = cmd_count;
    req_valid = 1'b1;
    req_address = a;
    chk({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    chk({tag, ".rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, ".rsp_data"}, rsp_data, exp_rsp);
    chk({tag, ".no_read"}, {31'd0, avmm_data_read}, 32'd0);
    chk({tag, ".no_cmd"}, 32'(cmd_count), 32'(c0));
    tick();
    chk({tag, ".rsp_pulse"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    chk("rst.ready", {31'd0, req_ready}, 32'd1);
    chk("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst.rsp_data", rsp_data, 32'd0);
    chk("rst.read", {31'd0, avmm_data_read}, 32'd0);
    chk("rst.addr", {16'd0, avmm_data_addr}, 32'd0);

    // Cold miss then sequential hit.
    miss("cold", 16'h0010, 16'h0010, 32'hAAAA0000, 32'hBBBB0001, 0, 1'b0, 1'b0, 32'hAAAA0000);
    hit("seq_hit", 16'h0011, 32'hBBBB0001);

    // Waitrequest stall for 5 cycles, response is the odd word.
    miss("stall", 16'h0021, 16'h0020, 32'h11110020, 32'h22220021, 5, 1'b0, 1'b0, 32'h22220021);

    // Invalidate between beats leaves the line invalid.
    miss("inv_rx", 16'h0100, 16'h0100, 32'h33330100, 32'h44440101, 0, 1'b1, 1'b0, 32'h33330100);
    miss("inv_rx2", 16'h0101, 16'h0100, 32'h55550100, 32'h66660101, 0, 1'b0, 1'b0, 32'h66660101);

    // Invalidate coincident with a would-be hit forces a refetch.
    miss("inv_idle", 16'h0100, 16'h0100, 32'h77770100, 32'h88880101, 0, 1'b0, 1'b1,
         32'h77770100);
    hit("inv_idle_hit", 16'h0101, 32'h88880101);

    // Top-of-space line.
    miss("wrap", 16'hFFFF, 16'hFFFE, 32'h9999FFFE, 32'hCCCCFFFF, 0, 1'b0, 1'b0, 32'hCCCCFFFF);
    hit("wrap_hit", 16'hFFFE, 32'h9999FFFE);

    // Reset after the first beat of a burst.
    req_valid = 1'b1;
    req_address = 16'h0040;
    tick();
    req_valid = 1'b0;
    chk("mid.read", {31'd0, avmm_data_read}, 32'd1);
    chk("mid.addr", {16'd0, avmm_data_addr}, 32'h0040);
    tick();
    tick();
    tick();
    avmm_data_readdatavalid = 1'b1;
    avmm_data_readdata = 32'h12340040;
    tick();
    avmm_data_readdatavalid = 1'b0;
    reset = 1'b1;
    chk("mid.rst_read", {31'd0, avmm_data_read}, 32'd0);
    tick();
    reset = 1'b0;
    chk("mid.ready", {31'd0, req_ready}, 32'd1);
    chk("mid.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid.rsp_data", rsp_data, 32'd0);
    chk("mid.read_after", {31'd0, avmm_data_read}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid.no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    miss("mid_retry", 16'h0041, 16'h0040, 32'hABCD0040, 32'hABCD0041, 0, 1'b0, 1'b0,
         32'hABCD0041);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
